// File: rtl/ps2_kbd_ctrl_if.sv
// PS/2 keyboard controller bus: receiver FIFO side and CPU event side.
// master = ps2_kbd_ctrl, slave = FIFO/CPU environment.
interface ps2_kbd_ctrl_if;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic       ps2_overflow;
    logic       ps2_rdn;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_ack;

    modport master (
        input  ps2_ready, ps2_data, ps2_overflow, key_ack,
        output ps2_rdn, key_valid, key_code, key_ext, key_break
    );

    modport slave (
        output ps2_ready, ps2_data, ps2_overflow, key_ack,
        input  ps2_rdn, key_valid, key_code, key_ext, key_break
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scancode sequencer: pops FIFO bytes, strips E0/F0/E1
// prefixes, filters status bytes and presents one key event at a time.
// Ports: clk, reset (async, active-low), bus (ps2_kbd_ctrl_if.master),
// err_flag (sticky). Optional KBD_MODS_EN adds mods[3:0]
// ({caps, alt, ctrl, shift}).
module ps2_kbd_ctrl #(
    parameter int PREFIX_TO = 1000000,
    parameter int TO_W      = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_kbd_ctrl_if.master        bus,
`ifdef KBD_MODS_EN
    output logic [3:0]            mods,
`endif
    output logic                  err_flag
);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TO - 1);

    state_t          state, state_nx;
    logic [7:0]      byte_r;
    logic            ext_p, brk_p;
    logic [2:0]      skip_cnt;
    logic [TO_W-1:0] to_cnt;

    logic rdn_nx;
    logic dec_skip, dec_e1, dec_e0, dec_f0;
    logic dec_bad, dec_key;
    logic is_status;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.ps2_ready && !bus.key_valid) state_nx = POP;
            POP:     state_nx = DECODE;
            DECODE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign is_status = (byte_r == 8'hAA) || (byte_r == 8'hFA) ||
                       (byte_r == 8'hFE) || (byte_r == 8'hEE);

    always_comb begin
        rdn_nx   = (state_nx != POP);
        dec_skip = 1'b0;
        dec_e1   = 1'b0;
        dec_e0   = 1'b0;
        dec_f0   = 1'b0;
        dec_bad  = 1'b0;
        dec_key  = 1'b0;
        if (state == DECODE) begin
            if (skip_cnt != 3'd0)                        dec_skip = 1'b1;
            else if (byte_r == 8'hE1)                    dec_e1   = 1'b1;
            else if (byte_r == 8'hE0)                    dec_e0   = 1'b1;
            else if (byte_r == 8'hF0)                    dec_f0   = 1'b1;
            else if (byte_r == 8'h00 || byte_r == 8'hFF) dec_bad  = 1'b1;
            else if (!(is_status && !ext_p && !brk_p))   dec_key  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ps2_rdn   <= 1'b1;
            bus.key_valid <= 1'b0;
            bus.key_code  <= 8'h00;
            bus.key_ext   <= 1'b0;
            bus.key_break <= 1'b0;
            err_flag      <= 1'b0;
            byte_r        <= 8'h00;
            ext_p         <= 1'b0;
            brk_p         <= 1'b0;
            skip_cnt      <= 3'd0;
            to_cnt        <= '0;
        end else begin
            bus.ps2_rdn <= rdn_nx;
            if (state == POP) byte_r <= bus.ps2_data;
            if (bus.key_valid && bus.key_ack) bus.key_valid <= 1'b0;

            // stale prefixes are dropped after a quiet period
            if (state == POP) begin
                to_cnt <= '0;
            end else if ((ext_p || brk_p) && state == IDLE) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt <= '0;
                    ext_p  <= 1'b0;
                    brk_p  <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            if (dec_skip) skip_cnt <= skip_cnt - 3'd1;
            if (dec_e1) begin
                skip_cnt <= 3'd7;
                ext_p    <= 1'b0;
                brk_p    <= 1'b0;
            end
            if (dec_e0) ext_p <= 1'b1;
            if (dec_f0) brk_p <= 1'b1;
            if (dec_bad) begin
                err_flag <= 1'b1;
                ext_p    <= 1'b0;
                brk_p    <= 1'b0;
            end
            if (dec_key) begin
                bus.key_code  <= byte_r;
                bus.key_ext   <= ext_p;
                bus.key_break <= brk_p;
                bus.key_valid <= 1'b1;
                ext_p         <= 1'b0;
                brk_p         <= 1'b0;
            end

            // overflow means the byte stream lost sync: drop all context
            if (bus.ps2_overflow) begin
                err_flag <= 1'b1;
                ext_p    <= 1'b0;
                brk_p    <= 1'b0;
                skip_cnt <= 3'd0;
            end
        end
    end

`ifdef KBD_MODS_EN
    logic lsh, rsh, lctl, rctl, lalt, ralt, caps;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsh  <= 1'b0;
            rsh  <= 1'b0;
            lctl <= 1'b0;
            rctl <= 1'b0;
            lalt <= 1'b0;
            ralt <= 1'b0;
            caps <= 1'b0;
        end else if (dec_key) begin
            unique case (1'b1)
                byte_r == 8'h12: lsh <= !brk_p;
                byte_r == 8'h59: rsh <= !brk_p;
                byte_r == 8'h14: begin
                    if (ext_p) rctl <= !brk_p;
                    else       lctl <= !brk_p;
                end
                byte_r == 8'h11: begin
                    if (ext_p) ralt <= !brk_p;
                    else       lalt <= !brk_p;
                end
                byte_r == 8'h58: begin
                    if (!ext_p && !brk_p) caps <= !caps;
                end
                default: ;
            endcase
        end
    end

    assign mods = {caps, lalt | ralt, lctl | rctl, lsh | rsh};
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl with a queue-based FIFO model.
// Short prefix timeout so the timeout path is reachable quickly.
module tb_ps2_kbd_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic err_flag;
`ifdef KBD_MODS_EN
    logic [3:0] mods;
`endif

    ps2_kbd_ctrl_if bus();

    ps2_kbd_ctrl #(
        .PREFIX_TO(50),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
`ifdef KBD_MODS_EN
        .mods(mods),
`endif
        .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    bit pend = 1'b0;
    int pops = 0;
    int checks = 0;
    int fails = 0;

    // FIFO model: the head is removed one negedge after the pop
    // strobe was seen, so the DUT samples a stable byte.
    always @(negedge clk) begin
        if (pend && fifo.size() != 0) void'(fifo.pop_front());
        pend = (bus.ps2_rdn == 1'b0);
        if (pend) pops++;
        bus.ps2_ready = (fifo.size() != 0);
        bus.ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        fifo.delete();
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic expect_ev(input string tag, input logic [7:0] code,
                             input logic ext, input logic brk);
        int n = 0;
        while (!bus.key_valid && n < 200) begin
            tick(1);
            n++;
        end
        chk({tag, "_valid"}, bus.key_valid, 1);
        chk({tag, "_code"}, bus.key_code, code);
        chk({tag, "_ext"}, bus.key_ext, ext);
        chk({tag, "_brk"}, bus.key_break, brk);
    endtask

    task automatic ack(input string tag);
        bus.key_ack = 1'b1;
        tick(1);
        bus.key_ack = 1'b0;
        chk({tag, "_ackclr"}, bus.key_valid, 0);
    endtask

    task automatic drain;
        int n = 0;
        while ((fifo.size() != 0 || pend) && n < 200) begin
            tick(1);
            n++;
        end
        tick(4);
    endtask

    initial begin
        int p;
        int n;
        bus.key_ack = 1'b0;
        bus.ps2_overflow = 1'b0;
        tick(2);
        chk("rst_rdn", bus.ps2_rdn, 1);
        chk("rst_valid", bus.key_valid, 0);
        chk("rst_code", bus.key_code, 0);
        chk("rst_ext", bus.key_ext, 0);
        chk("rst_brk", bus.key_break, 0);
        chk("rst_err", err_flag, 0);
        reset = 1'b1;
        tick(2);

        // single byte: pulse width and latency
        fifo.push_back(8'h1C);
        n = 0;
        while (bus.ps2_rdn && n < 20) begin
            tick(1);
            n++;
        end
        chk("t1_rdn_low", bus.ps2_rdn, 0);
        chk("t1_nv0", bus.key_valid, 0);
        tick(1);
        chk("t1_rdn_1cyc", bus.ps2_rdn, 1);
        chk("t1_nv1", bus.key_valid, 0);
        tick(1);
        chk("t1_lat", bus.key_valid, 1);
        expect_ev("t1", 8'h1C, 0, 0);
        ack("t1");

        // extended break
        p = pops;
        fifo.push_back(8'hE0);
        fifo.push_back(8'hF0);
        fifo.push_back(8'h75);
        expect_ev("t2", 8'h75, 1, 1);
        chk("t2_pops", pops - p, 3);
        ack("t2");

        // stall while an event is pending
        fifo.push_back(8'h1C);
        fifo.push_back(8'h32);
        fifo.push_back(8'h21);
        expect_ev("t3a", 8'h1C, 0, 0);
        p = pops;
        tick(20);
        chk("t3_stall", pops - p, 0);
        chk("t3_hold_v", bus.key_valid, 1);
        chk("t3_hold_c", bus.key_code, 8'h1C);
        ack("t3a");
        tick(1);
        chk("t3_pop_after_ack", bus.ps2_rdn, 0);
        expect_ev("t3b", 8'h32, 0, 0);
        ack("t3b");
        expect_ev("t3c", 8'h21, 0, 0);
        ack("t3c");

        // pause sequence discarded
        p = pops;
        fifo.push_back(8'hE1);
        fifo.push_back(8'h14);
        fifo.push_back(8'h77);
        fifo.push_back(8'hE1);
        fifo.push_back(8'hF0);
        fifo.push_back(8'h14);
        fifo.push_back(8'hF0);
        fifo.push_back(8'h77);
        fifo.push_back(8'h1C);
        expect_ev("t4", 8'h1C, 0, 0);
        chk("t4_pops", pops - p, 9);
        ack("t4");

        // status bytes
        fifo.push_back(8'hAA);
        drain();
        chk("t4_aa_noev", bus.key_valid, 0);
        fifo.push_back(8'hFA);
        fifo.push_back(8'hFE);
        fifo.push_back(8'hEE);
        fifo.push_back(8'h29);
        expect_ev("t4_stat", 8'h29, 0, 0);
        ack("t4_stat");
        fifo.push_back(8'hF0);
        fifo.push_back(8'hAA);
        expect_ev("t4_f0aa", 8'hAA, 0, 1);
        ack("t4_f0aa");

        // prefix timeout and its boundary
        fifo.push_back(8'hE0);
        drain();
        tick(60);
        fifo.push_back(8'h1C);
        expect_ev("t5_to", 8'h1C, 0, 0);
        ack("t5_to");
        fifo.push_back(8'hE0);
        drain();
        tick(10);
        fifo.push_back(8'h75);
        expect_ev("t5_keep", 8'h75, 1, 0);
        ack("t5_keep");

        // illegal byte sets err and drops prefix
        chk("t5_err0", err_flag, 0);
        fifo.push_back(8'hE0);
        fifo.push_back(8'h00);
        fifo.push_back(8'h1C);
        expect_ev("t5_bad", 8'h1C, 0, 0);
        chk("t5_err1", err_flag, 1);
        ack("t5_bad");

        // overflow sets err and clears skip state
        do_reset();
        chk("t6_err_rst", err_flag, 0);
        fifo.push_back(8'hE1);
        drain();
        bus.ps2_overflow = 1'b1;
        tick(1);
        bus.ps2_overflow = 1'b0;
        tick(5);
        chk("t6_ovf_err", err_flag, 1);
        fifo.push_back(8'h1C);
        expect_ev("t6_resync", 8'h1C, 0, 0);
        ack("t6");

`ifdef KBD_MODS_EN
        do_reset();
        chk("m_rst", mods, 4'b0000);
        fifo.push_back(8'h12);
        expect_ev("m_sh", 8'h12, 0, 0);
        chk("m_sh_mods", mods, 4'b0001);
        ack("m_sh");
        fifo.push_back(8'h58);
        expect_ev("m_caps", 8'h58, 0, 0);
        chk("m_caps_mods", mods, 4'b1001);
        ack("m_caps");
        fifo.push_back(8'hF0);
        fifo.push_back(8'h12);
        expect_ev("m_shup", 8'h12, 0, 1);
        chk("m_shup_mods", mods, 4'b1000);
        ack("m_shup");
        fifo.push_back(8'hE0);
        fifo.push_back(8'h14);
        expect_ev("m_rctl", 8'h14, 1, 0);
        chk("m_rctl_mods", mods, 4'b1010);
        ack("m_rctl");
`endif

        // reset while strobe is low
        do_reset();
        fifo.push_back(8'h1C);
        n = 0;
        while (bus.ps2_rdn && n < 20) begin
            tick(1);
            n++;
        end
        chk("t7_rdn_low", bus.ps2_rdn, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_rdn_async", bus.ps2_rdn, 1);
        chk("t7_valid", bus.key_valid, 0);
        tick(2);
        reset = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
